// File: rtl/tile_reader.sv
// tile_reader: loads one TILE_W x TILE_H tile from the ARGB8888 framebuffer in
// DDR3 into the tile buffer. Each channel is widened from 8-bit to u0.10.
// One framebuffer row is fetched per burst, buffered, then drained one pixel
// per cycle into the tile buffer.
//
// Optional build macro: TILE_READER_ALPHA_EN
//   defined     - alpha is converted from A8 like the colour channels
//   not defined - alpha is written as 16'h03FF (opaque) and A8 is dropped
//
// Ports:
//   clk, reset            system clock, asynchronous active-high reset
//   start/done/busy       scheduler handshake (start pulse, done pulse, busy level)
//   tile_px, tile_py      tile origin in pixels, captured on an accepted start
//   rd_*                  ddram_ctrl read port (request, burst data return)
//   tb_wr_*               tile buffer write port, address {row, col}
//
// state  | meaning
// IDLE   | waiting for start
// REQ    | issue one burst read for the current row once rd_busy is low
// RECV   | collect TILE_W/2 returned beats into the line buffer
// DRAIN  | write TILE_W pixels of the row to the tile buffer
// DONE   | last pixel written; done pulses on the way back to IDLE

module tile_reader #(
  parameter logic [28:0] FB_BASE      = 29'h06000000,
  parameter int          STRIDE_WORDS = 320,
  parameter int          TILE_W       = 32,
  parameter int          TILE_H       = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        done,
  output logic        busy,
  input  logic [15:0] tile_px,
  input  logic [15:0] tile_py,
  output logic [28:0] rd_addr,
  output logic [7:0]  rd_burstcnt,
  output logic        rd_req,
  input  logic        rd_busy,
  input  logic [63:0] rd_data,
  input  logic        rd_valid,
  output logic [9:0]  tb_wr_addr,
  output logic [63:0] tb_wr_data,
  output logic        tb_wr_en
);

  localparam int         BEATS     = TILE_W / 2;
  localparam int         BEAT_W    = $clog2(BEATS);
  localparam int         COL_W     = $clog2(TILE_W);
  localparam int         ROW_W     = $clog2(TILE_H);
  localparam logic [7:0] BURST_LEN = 8'(BEATS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_RECV,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [15:0]       org_px;
  logic [15:0]       org_py;
  logic [ROW_W-1:0]  row;
  logic [COL_W-1:0]  col;
  logic [BEAT_W-1:0] beat;
  logic [63:0]       line_buf [BEATS];

  logic        last_beat;
  logic        last_col;
  logic        last_row;
  logic [28:0] req_y;
  logic [28:0] req_addr;
  logic [63:0] drain_word;
  logic [31:0] drain_px;
  logic [15:0] a16;
  logic [63:0] px_conv;

  // 8-bit to u0.10 by bit replication, so 0xFF maps to full scale 0x3FF.
  function automatic logic [15:0] to_u010(input logic [7:0] x);
    return {6'b0, x, x[7:6]};
  endfunction

  assign last_beat = (beat == BEAT_W'(BEATS - 1));
  assign last_col  = (col == COL_W'(TILE_W - 1));
  assign last_row  = (row == ROW_W'(TILE_H - 1));
  assign busy      = (state != S_IDLE);

  // Burst address is kept at 29 bits so it wraps with the DDRAM word space.
  always_comb begin
    req_y    = 29'(org_py) + 29'(row);
    req_addr = FB_BASE + req_y * 29'(STRIDE_WORDS) + 29'(org_px[15:1]);
  end

  // Two pixels per beat: even pixel in the low half, odd pixel in the high half.
  always_comb begin
    drain_word = line_buf[col[COL_W-1:1]];
    drain_px   = col[0] ? drain_word[63:32] : drain_word[31:0];
  end

`ifdef TILE_READER_ALPHA_EN
  assign a16 = to_u010(drain_px[31:24]);
`else
  logic alpha_unused;
  assign alpha_unused = ^drain_px[31:24];
  assign a16 = 16'h03FF;
`endif

  assign px_conv = {a16, to_u010(drain_px[7:0]), to_u010(drain_px[15:8]),
                    to_u010(drain_px[23:16])};

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_REQ;
      S_REQ:   if (!rd_busy) state_nxt = S_RECV;
      S_RECV:  if (rd_valid && last_beat) state_nxt = S_DRAIN;
      S_DRAIN: if (last_col) state_nxt = last_row ? S_DONE : S_REQ;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      org_px      <= '0;
      org_py      <= '0;
      row         <= '0;
      col         <= '0;
      beat        <= '0;
      rd_req      <= 1'b0;
      rd_addr     <= '0;
      rd_burstcnt <= '0;
      tb_wr_en    <= 1'b0;
      tb_wr_addr  <= '0;
      tb_wr_data  <= '0;
      done        <= 1'b0;
    end else begin
      rd_req   <= 1'b0;
      tb_wr_en <= 1'b0;
      done     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            org_px <= tile_px;
            org_py <= tile_py;
            row    <= '0;
          end
        end
        S_REQ: begin
          if (!rd_busy) begin
            rd_req      <= 1'b1;
            rd_addr     <= req_addr;
            rd_burstcnt <= BURST_LEN;
            beat        <= '0;
          end
        end
        S_RECV: begin
          if (rd_valid) begin
            beat <= beat + 1'b1;
            if (last_beat) col <= '0;
          end
        end
        S_DRAIN: begin
          tb_wr_en   <= 1'b1;
          tb_wr_addr <= 10'({row, col});
          tb_wr_data <= px_conv;
          col        <= col + 1'b1;
          if (last_col && !last_row) row <= row + 1'b1;
        end
        S_DONE: done <= 1'b1;
        default: ;
      endcase
    end
  end

  // Line buffer holds data only; no reset needed since every word is
  // rewritten before it is drained.
  always_ff @(posedge clk) begin
    if (state == S_RECV && rd_valid) line_buf[beat] <= rd_data;
  end

endmodule

// File: tb/tb_tile_reader.sv
module tb_tile_reader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        done;
  logic        busy;
  logic [15:0] tile_px = '0;
  logic [15:0] tile_py = '0;
  logic [28:0] rd_addr;
  logic [7:0]  rd_burstcnt;
  logic        rd_req;
  logic        rd_busy = 1'b0;
  logic [63:0] rd_data = '0;
  logic        rd_valid = 1'b0;
  logic [9:0]  tb_wr_addr;
  logic [63:0] tb_wr_data;
  logic        tb_wr_en;

  tile_reader dut (
    .clk(clk), .reset(reset), .start(start), .done(done), .busy(busy),
    .tile_px(tile_px), .tile_py(tile_py),
    .rd_addr(rd_addr), .rd_burstcnt(rd_burstcnt), .rd_req(rd_req),
    .rd_busy(rd_busy), .rd_data(rd_data), .rd_valid(rd_valid),
    .tb_wr_addr(tb_wr_addr), .tb_wr_data(tb_wr_data), .tb_wr_en(tb_wr_en)
  );

  always #5 clk = ~clk;

`ifdef TILE_READER_ALPHA_EN
  localparam bit ALPHA_EN = 1'b1;
`else
  localparam bit ALPHA_EN = 1'b0;
`endif

  int n_chk = 0, n_pass = 0;
  int wr_cnt = 0, req_cnt = 0, done_cnt = 0, sb_err = 0, beats_total = 0;
  int spur_sent = 0, spur_target = 0;
  int wr_base = 0, req_base = 0, done_base = 0, err_base = 0, beats_base = 0;
  logic [28:0] first_addr = '0, last_addr = '0;
  logic [63:0] first_wdata = '0;
  logic [15:0] mdl_px = '0, mdl_py = '0;
  bit          force_en = 1'b0;
  logic [31:0] force_px = '0;
  int          lat = 2;
  bit          gaps_en = 1'b0;
  bit          resp_busy = 1'b0;
  logic [28:0] req_q[$];

  function automatic logic [63:0] mem_word(input logic [28:0] a);
    logic [7:0] b0, b1, b2;
    b0 = a[7:0]; b1 = a[15:8]; b2 = a[23:16];
    return {b0 + 8'd1, b1 ^ 8'hC3, b0 ^ 8'h99, b2 + b0,
            b0 ^ 8'h3C, b1, b0 + 8'd7, b2 ^ 8'h5A};
  endfunction

  function automatic logic [15:0] ch(input logic [7:0] x);
    return (16'(x) << 2) | (16'(x) >> 6);
  endfunction

  function automatic logic [63:0] exp_px(input logic [31:0] p);
    logic [15:0] a16;
    a16 = ALPHA_EN ? ch(p[31:24]) : 16'h03FF;
    return {a16, ch(p[7:0]), ch(p[15:8]), ch(p[23:16])};
  endfunction

  function automatic logic [28:0] row_addr(input int r);
    return 29'h06000000 + (29'(mdl_py) + 29'(r)) * 29'd320 + 29'(mdl_px >> 1);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    int ri, wi, er, ec;
    logic [63:0] w;
    if (!reset) begin
      if (rd_req) begin
        ri = req_cnt - req_base;
        if (rd_addr !== row_addr(ri)) sb_err++;
        if (rd_burstcnt !== 8'd16) sb_err++;
        if (wr_cnt - wr_base != ri * 32) sb_err++;
        if (ri == 0) first_addr = rd_addr;
        last_addr = rd_addr;
        req_q.push_back(rd_addr);
        req_cnt++;
      end
      if (tb_wr_en) begin
        wi = wr_cnt - wr_base;
        er = wi / 32;
        ec = wi % 32;
        w = force_en ? {force_px, force_px} : mem_word(row_addr(er) + 29'(ec / 2));
        if (tb_wr_addr !== 10'(wi)) sb_err++;
        if (tb_wr_data !== exp_px((ec % 2) != 0 ? w[63:32] : w[31:0])) sb_err++;
        if (beats_total - beats_base < (er + 1) * 16) sb_err++;
        if (wi == 0) first_wdata = tb_wr_data;
        wr_cnt++;
      end
      if (done) begin
        if (wr_cnt - wr_base != 1024) sb_err++;
        done_cnt++;
      end
    end
  end

  // DDRAM read responder: one burst at a time, optional random beat gaps;
  // also injects unsolicited beats on request from the main sequence.
  always begin
    logic [28:0] a;
    @(negedge clk);
    if (!reset && req_q.size() > 0) begin
      a = req_q.pop_front();
      resp_busy = 1'b1;
      repeat (lat) @(negedge clk);
      for (int i = 0; i < 16; i++) begin
        if (gaps_en) repeat ($urandom_range(0, 3)) @(negedge clk);
        rd_data  = force_en ? {force_px, force_px} : mem_word(a + 29'(i));
        rd_valid = 1'b1;
        beats_total++;
        @(negedge clk);
        rd_valid = 1'b0;
      end
      resp_busy = 1'b0;
    end else if (spur_sent < spur_target) begin
      rd_data  = 64'hDEAD_BEEF_0BAD_F00D;
      rd_valid = 1'b1;
      spur_sent++;
      @(negedge clk);
      rd_valid = 1'b0;
    end
  end

  task automatic wait_resp_idle();
    for (int i = 0; i < 3000 && (resp_busy || req_q.size() > 0 || spur_sent < spur_target); i++)
      @(negedge clk);
    if (resp_busy || req_q.size() > 0 || spur_sent < spur_target)
      chk("resp_idle_timeout", 64'd0, 64'd1);
  endtask

  task automatic begin_tile(input logic [15:0] px, input logic [15:0] py);
    wait_resp_idle();
    mdl_px = px; mdl_py = py;
    wr_base = wr_cnt; req_base = req_cnt; done_base = done_cnt;
    err_base = sb_err; beats_base = beats_total;
    tile_px = px; tile_py = py; start = 1'b1;
    @(negedge clk);
    start = 1'b0; tile_px = 16'h5555; tile_py = 16'h7777;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 20000 && done_cnt == done_base; i++) @(negedge clk);
    if (done_cnt == done_base) chk("done_timeout", 64'd0, 64'd1);
    repeat (8) @(negedge clk);
  endtask

  task automatic check_tile(input string tag, input logic [28:0] a0, input logic [28:0] a1);
    chk({tag, "_first_rd_addr"}, 64'(first_addr), 64'(a0));
    chk({tag, "_last_rd_addr"}, 64'(last_addr), 64'(a1));
    chk({tag, "_wr_count"}, 64'(wr_cnt - wr_base), 64'd1024);
    chk({tag, "_req_count"}, 64'(req_cnt - req_base), 64'd32);
    chk({tag, "_done_count"}, 64'(done_cnt - done_base), 64'd1);
    chk({tag, "_scoreboard_errs"}, 64'(sb_err - err_base), 64'd0);
    chk({tag, "_busy_after"}, 64'(busy), 64'd0);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_ctrl"}, 64'({done, busy, rd_req, tb_wr_en}), 64'd0);
    chk({tag, "_rd_addr"}, 64'(rd_addr), 64'd0);
    chk({tag, "_rd_burstcnt"}, 64'(rd_burstcnt), 64'd0);
    chk({tag, "_tb_wr_addr"}, 64'(tb_wr_addr), 64'd0);
    chk({tag, "_tb_wr_data"}, tb_wr_data, 64'd0);
  endtask

  typedef struct {
    logic [15:0] px, py;
    bit          fen;
    logic [31:0] fpx;
    int          lat;
    bit          gaps;
    logic [28:0] a0, a1;
    logic [63:0] wd;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int w0, d0;
    logic [15:0] a40;
    int k;
    a40 = ALPHA_EN ? 16'h0101 : 16'h03FF;
    vecs[0] = '{16'd0, 16'd0, 1'b0, 32'd0, 2, 1'b0, 29'h06000000, 29'h060026C0, 64'd0};
    vecs[1] = '{16'd64, 16'd32, 1'b1, 32'hFF80_4000, 1, 1'b1, 29'h06002820, 29'h06004EE0,
                64'h03FF_0000_0101_0202};
    vecs[2] = '{16'd3, 16'd1, 1'b1, 32'h4012_3456, 3, 1'b1, 29'h06000141, 29'h06002801,
                {a40, 48'h0159_00D0_0048}};
    vecs[3] = '{16'hFFFE, 16'hFFFF, 1'b0, 32'd0, 0, 1'b1, 29'h07407EBF, 29'h0740A57F, 64'd0};

    repeat (3) @(negedge clk);
    chk_zero_outputs("reset_state");
    reset = 1'b0;
    repeat (2) @(negedge clk);

    for (k = 0; k < 4; k++) begin
      force_en = vecs[k].fen; force_px = vecs[k].fpx;
      lat = vecs[k].lat; gaps_en = vecs[k].gaps;
      begin_tile(vecs[k].px, vecs[k].py);
      wait_done();
      check_tile($sformatf("vec%0d", k), vecs[k].a0, vecs[k].a1);
      if (vecs[k].fen) chk($sformatf("vec%0d_wr_data", k), first_wdata, vecs[k].wd);
    end

    // rd_busy held in REQ
    force_en = 1'b0; lat = 2; gaps_en = 1'b0;
    rd_busy = 1'b1;
    begin_tile(16'd256, 16'd128);
    repeat (20) @(negedge clk);
    chk("busy_hold_no_req", 64'(req_cnt - req_base), 64'd0);
    chk("busy_hold_busy", 64'(busy), 64'd1);
    rd_busy = 1'b0;
    repeat (3) @(negedge clk);
    chk("busy_release_one_req", 64'(req_cnt - req_base), 64'd1);
    wait_done();
    check_tile("busy", 29'h0600A080, 29'h0600C740);

    // spurious beats in IDLE, start and spurious beats during DRAIN
    w0 = wr_cnt; d0 = done_cnt;
    spur_target += 4;
    wait_resp_idle();
    repeat (3) @(negedge clk);
    chk("spur_idle_writes", 64'(wr_cnt - w0), 64'd0);
    chk("spur_idle_done", 64'(done_cnt - d0), 64'd0);
    chk("spur_idle_busy", 64'(busy), 64'd0);
    lat = 1; gaps_en = 1'b1;
    begin_tile(16'd32, 16'd0);
    for (int i = 0; i < 5000 && wr_cnt - wr_base < 40; i++) @(negedge clk);
    if (wr_cnt - wr_base < 40) chk("drain_wait_timeout", 64'd0, 64'd1);
    tile_px = 16'h0200; tile_py = 16'h0300; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    spur_target += 3;
    wait_done();
    check_tile("drain_start", 29'h06000010, 29'h060026D0);

    // reset during RECV of row 5
    lat = 2; gaps_en = 1'b1;
    begin_tile(16'd0, 16'd0);
    for (int i = 0; i < 5000 && !(req_cnt - req_base == 6 && beats_total - beats_base >= 84); i++)
      @(negedge clk);
    if (!(req_cnt - req_base == 6 && beats_total - beats_base >= 84))
      chk("row5_wait_timeout", 64'd0, 64'd1);
    #2 reset = 1'b1;
    #1 chk_zero_outputs("async_reset");
    @(negedge clk);
    wait_resp_idle();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("post_reset_busy", 64'(busy), 64'd0);
    gaps_en = 1'b0;
    begin_tile(16'd0, 16'd0);
    wait_done();
    check_tile("after_reset", 29'h06000000, 29'h060026C0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/tile_reader.md
Name: tile_reader

Overview:
- Inverse of the tile writer: loads one 32x32 tile from the DDR3 ARGB8888 framebuffer into the tile buffer BRAM as u0.10 per channel.
- Lets the rasterizer blend onto existing framebuffer contents, or reload a tile.
- Sits between ddram_ctrl (read port) and the tile buffer write port. Sequenced by the tile scheduler via start/done.

Parameters:
- FB_BASE, 29'h06000000, framebuffer base in 64-bit DDRAM words (byte 0x30000000 >> 3).
- STRIDE_WORDS, 320, framebuffer line stride in 64-bit words (640 px * 4 B / 8).
- TILE_W, 32, tile width in pixels; must be even.
- TILE_H, 32, tile height in rows.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; begin tile load (ignored unless IDLE)
- done  out  1  one-cycle pulse when the final pixel is written
- busy  out  1  high in every state except IDLE
- tile_px  in  16  tile origin X in pixels; sampled on accepted start; bit 0 ignored
- tile_py  in  16  tile origin Y in pixels; sampled on accepted start
- rd_addr  out  29  DDRAM word address of burst
- rd_burstcnt  out  8  burst length; always TILE_W/2 (16)
- rd_req  out  1  one-cycle request pulse
- rd_busy  in  1  controller cannot accept a request
- rd_data  in  64  returned word: [31:0] even pixel, [63:32] odd pixel; each {A8,R8,G8,B8}, MSB first
- rd_valid  in  1  rd_data beat valid
- tb_wr_addr  out  10  tile buffer address {row[4:0], col[4:0]}
- tb_wr_data  out  64  {A16,B16,G16,R16}, R in [15:0]
- tb_wr_en  out  1  tile buffer write strobe

Behaviour:
- Reset (async, active-high): state IDLE. done, busy, rd_req, tb_wr_en = 0. rd_addr, rd_burstcnt, tb_wr_addr, tb_wr_data = 0. Row and column counters = 0.
- Reset mid-operation: abandons the tile immediately. Any later rd_valid beats are ignored because the FSM is in IDLE.
- States:
  - IDLE: on start, latch tile_px/tile_py, row <= 0, go to REQ.
  - REQ: when !rd_busy, pulse rd_req for exactly 1 cycle with:
    - rd_addr = FB_BASE + (tile_py+row)*STRIDE_WORDS + (tile_px>>1), computed at 29 bits, wrap modulo 2^29;
    - rd_burstcnt = 16.
    Clear the beat counter and go to RECV. While rd_busy is high, stay in REQ with rd_req low.
  - RECV: each rd_valid beat is stored in a 16x64 line buffer at index beat; beat increments. After beat 15 is stored, go to DRAIN with col <= 0.
  - DRAIN: one pixel per cycle, 32 consecutive cycles.
    - Source: line buffer word col>>1, half col[0].
    - tb_wr_en = 1, tb_wr_addr = {row, col}, all registered.
    - At col = 31: if row = TILE_H-1 go to DONE, else row+1 and go to REQ.
  - DONE: done = 1 for one cycle, busy drops, return to IDLE.
- Conversion per 8-bit channel x: u0.10 = {6'b0, x, x[7:6]} (0x00 -> 0x000, 0xFF -> 0x3FF, 0x80 -> 0x202). The tile writer's >>2 reproduces x exactly.
- Ordering: rows written top to bottom, pixels left to right. Exactly TILE_W*TILE_H writes per tile; no duplicated or skipped addresses.
- Only one burst outstanding at a time; a new request is issued only after the full row has drained.
- rd_valid in IDLE, REQ, DRAIN or DONE: ignored.
- start while busy: ignored; the latched origin is unchanged.
- Minimum per-row latency: 1 (REQ) + controller latency + 16 beats + 32 drain cycles.

Optional Feature:
- TILE_READER_ALPHA_EN defined: alpha converted from A8 with the same rule as the colour channels.
- Not defined: tb_wr_data[63:48] forced to 16'h03FF (opaque), and A8 is ignored.

Test Plan:
- Origin (0,0), framebuffer filled with word index pattern -> 32 bursts:
  - rd_addr 0x06000000, 0x06000140, ... 0x06000000+31*320;
  - 1024 tb writes in address order 0..1023;
  - done pulses once, after the last write.
- Origin (64,32) -> first rd_addr = 0x06000000+32*320+32 = 0x06002820. Pixel 0xFF80_4000 (A,R,G,B) -> tb_wr_data {A,0x03FF? ,B=0x000,G=0x101,R=0x202}; alpha field per macro setting (0x3FF with macro for A=0xFF, 0x3FF without).
- Alpha check: pixel A=0x40 -> A16 = 0x0101 with TILE_READER_ALPHA_EN, 0x03FF without.
- rd_busy held high 20 cycles in REQ -> rd_req stays low, then exactly one pulse. rd_valid beats with random gaps -> data unchanged, no writes until beat 15.
- start pulsed during DRAIN, and spurious rd_valid in IDLE -> no effect on writes, addresses or done count.
- Reset asserted mid-RECV of row 5 -> all outputs 0 asynchronously. A new start then loads a full tile correctly from row 0.
- Round trip: tile_reader then tile_writer on the same tile -> framebuffer bit-identical (A=0xFF).
